hololink_apb_regfile: RTL

HOLOLINK_APB_REGFILE -- requirements
Module: hololink_apb_regfile

---
 rtl/hololink_apb_regfile.sv | 113 +++++++++++
 1 files changed

// File: rtl/hololink_apb_regfile.sv
// APB register file: word 0 is a read-only ID, words 1..N_REG-1 are RW with byte strobes.
// Define HOLOLINK_APB_REGFILE_WAIT_EN to insert one wait state per transfer.
module hololink_apb_regfile #(
    parameter int          N_REG       = 16,
    parameter logic [31:0] REG_ID      = 32'h4846_0001,
    parameter logic [31:0] REG_RST_VAL = 32'h0000_0000
) (
    input  logic                  i_apb_clk,
    input  logic                  i_apb_rst,
    input  logic                  i_apb_psel,
    input  logic                  i_apb_penable,
    input  logic                  i_apb_pwrite,
    input  logic [31:0]           i_apb_paddr,
    input  logic [31:0]           i_apb_pwdata,
    input  logic [3:0]            i_apb_pstrb,
    output logic                  o_apb_pready,
    output logic [31:0]           o_apb_prdata,
    output logic                  o_apb_pserr,
    output logic [32*N_REG-1:0]   o_reg,
    output logic [N_REG-1:0]      o_wr_stb
);

`ifdef HOLOLINK_APB_REGFILE_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_rst_q;
    logic [31:0]            r_addr, r_wdata;
    logic [3:0]             r_strb;
    logic                   r_write;
    logic [N_REG-1:1][31:0] r_reg;
    logic [N_REG-1:0]       r_wr_stb;

    logic        w_setup, w_valid, w_done, w_commit, w_err;
    logic [5:0]  w_idx;
    logic [31:0] w_rd_word;

    // Setups in the first cycle after reset are ignored.
    assign w_setup  = i_apb_psel & ~i_apb_penable & ~r_rst_q;
    assign w_idx    = r_addr[7:2];
    assign w_valid  = (r_addr[1:0] == 2'b00) && (r_addr[31:8] == 24'd0) && (int'(w_idx) < N_REG);
    assign w_done   = (r_state == DONE) && i_apb_psel && !i_apb_rst;
    assign w_commit = w_done && r_write && w_valid && (w_idx != 6'd0) && (r_strb != 4'd0);
    assign w_err    = r_write ? (!w_valid || w_idx == 6'd0) : !w_valid;

    always_comb begin
        w_rd_word = '0;
        if (w_valid) begin
            if (w_idx == 6'd0) w_rd_word = REG_ID;
            for (int i = 1; i < N_REG; i++)
                if (w_idx == 6'(i)) w_rd_word = r_reg[i];
        end
    end

    assign o_apb_pready = w_done;
    assign o_apb_pserr  = w_done & w_err;
    assign o_apb_prdata = (w_done && !r_write) ? w_rd_word : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_setup) w_state_nxt = WAIT_EN ? WAIT : DONE;
            WAIT:    w_state_nxt = i_apb_psel ? DONE : IDLE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_apb_clk) begin
        r_rst_q <= i_apb_rst;
        if (i_apb_rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_setup) begin
                r_addr  <= i_apb_paddr;
                r_wdata <= i_apb_pwdata;
                r_strb  <= i_apb_pstrb;
                r_write <= i_apb_pwrite;
            end
        end
    end

    always_ff @(posedge i_apb_clk) begin
        r_wr_stb <= '0;
        for (int i = 1; i < N_REG; i++) begin
            if (i_apb_rst) begin
                r_reg[i] <= REG_RST_VAL;
            end else if (w_commit && w_idx == 6'(i)) begin
                r_wr_stb[i] <= 1'b1;
                for (int b = 0; b < 4; b++)
                    if (r_strb[b]) r_reg[i][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

    // Outputs are forced to their reset values for the whole time reset is held.
    assign o_reg[31:0] = REG_ID;
    for (genvar gi = 1; gi < N_REG; gi++) begin : g_oreg
        assign o_reg[32*gi +: 32] = i_apb_rst ? REG_RST_VAL : r_reg[gi];
    end
    assign o_wr_stb = i_apb_rst ? '0 : r_wr_stb;

endmodule
